tournament_feed: RTL and testbench
==================================

TOURNAMENT_FEED -- requirements
Module: tournament_feed

Interface
REQ-001 SHALL take parameter NUM_UNITS from pkg_bram_if; default 16; number of request slots.
REQ-002 SHALL take parameter WIDTH_UNITS from pkg_bram_if; default 4; rank width, with NUM_UNITS <= 2^WIDTH_UNITS.
REQ-003 SHALL have port clock  in  1  single clock, all state on the rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port I_Req  in  NUM_UNITS  per-slot request, sampled each cycle.
REQ-006 SHALL have port I_Win_Valid  in  NUM_UNITS  one-hot winner flags returned by the tournament.
REQ-007 SHALL have port I_Grant  in  1  consumer accepts the current winner this cycle.
REQ-008 SHALL have port O_Entry  out  [WIDTH_UNITS:0] x NUM_UNITS  tournament entries: MSB = empty flag, LSBs = rank.
REQ-009 SHALL have port O_Busy  out  NUM_UNITS  slot-pending flags.
REQ-010 SHALL have port O_Req  out  1  at least one slot pending.
REQ-011 SHALL have port O_Count  out  WIDTH_UNITS+1  number of pending slots.
REQ-012 SHALL have port O_Err  out  1  one-cycle pulse on a protocol violation.

Function
REQ-013 SHALL give each slot two states: EMPTY and PENDING.
REQ-014 SHALL encode O_Entry[i] as all-ones when EMPTY and {1'b0, rank[i]} when PENDING, so the oldest pending slot has the smallest value.
REQ-015 SHALL register all outputs; a request sampled at edge t SHALL appear on O_Entry/O_Busy/O_Count after edge t.
REQ-016 SHALL move an EMPTY slot with I_Req[i]=1 to PENDING.
REQ-017 SHALL ignore I_Req[i] while slot i is PENDING; the request SHALL neither be queued nor change rank.
REQ-018 SHALL make a valid grant when I_Grant=1 and I_Win_Valid is one-hot on a PENDING slot w.
REQ-019 SHALL, on a valid grant, set slot w EMPTY and decrement every pending rank greater than rank[w] by 1.
REQ-020 SHALL assign each new request the rank base + k, where base is O_Count minus 1 if a valid grant occurs in the same cycle (otherwise O_Count), and k is the number of lower-indexed slots newly accepted in the same cycle.
REQ-021 SHALL, when slot w is granted and I_Req[w]=1 in the same cycle, clear slot w and ignore that request; it SHALL be accepted in the next cycle if still asserted.
REQ-022 SHALL treat as a protocol error any cycle with I_Grant=1 and I_Win_Valid zero, non-one-hot, or pointing to an EMPTY slot: no state change, O_Err=1 the next cycle.
REQ-023 SHALL ignore I_Win_Valid while I_Grant=0, with no error.
REQ-024 SHALL update O_Count by +accepted-requests minus (valid grant ? 1 : 0); it SHALL never exceed NUM_UNITS or underflow.
REQ-025 SHALL keep pending ranks a permutation of 0..O_Count-1 at all times.
REQ-026 SHALL drive O_Req as (O_Count != 0).

Reset
REQ-027 SHALL, while reset=0 at an edge, set all slots EMPTY, O_Entry all-ones, O_Busy=0, O_Count=0, O_Req=0, O_Err=0.
REQ-028 SHALL abandon in-flight requests and grants when reset is asserted mid-operation; I_Req and I_Grant SHALL be ignored in that cycle.

Structure
REQ-029 SHALL place the slot-state typedef, the entry typedef ([WIDTH_UNITS:0]) and the EMPTY entry constant in pkg_bram_if, together with NUM_UNITS and WIDTH_UNITS.
REQ-030 SHALL instantiate one sub-module, tournament_feed_slot, per slot to hold state and rank; rank base, prefix count and winner rank are computed in the parent.
REQ-031 SHALL NOT contain the tournament; O_Entry connects directly to the TournamentW entry inputs, and its O_Valid plus the external accept drive I_Win_Valid/I_Grant.

Verification (NUM_UNITS=16, WIDTH_UNITS=4)
REQ-032 Reset: hold reset=0 for 2 cycles with I_Req=16'hFFFF -> O_Entry all 5'h1F, O_Count=0, O_Busy=0.
REQ-033 Simultaneous requests: I_Req=16'h0029 for one cycle -> ranks slot0=0, slot3=1, slot5=2; O_Count=3.
REQ-034 Grant middle: with slots 0/3/5 at ranks 0/1/2, grant slot3 -> slot3 5'h1F, slot5 rank 1, slot0 rank 0; O_Count=2.
REQ-035 Grant plus requests: slots 0/5 pending at ranks 0/1; grant slot0 while I_Req=16'h0101 -> slot0 EMPTY, slot5=0, slot8=1; O_Count=2; slot0 becomes PENDING next cycle at rank 2.
REQ-036 Errors: I_Grant=1 with I_Win_Valid=16'h0003, then with I_Win_Valid on an EMPTY slot -> O_Err pulses after each, state unchanged.
REQ-037 Full: request all 16 slots, then grant 16 times in tournament order -> slots granted in arrival order; O_Count falls 16..0, no wrap.

Source files
------------

// File: rtl/pkg_bram_if.sv
// Shared types and sizing for the tournament feed.
// Entries sort so that the oldest pending slot has the smallest value.
package pkg_bram_if;

  localparam int NUM_UNITS   = 16;
  localparam int WIDTH_UNITS = 4;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_PENDING
  } slot_state_t;

  typedef logic [WIDTH_UNITS:0] entry_t;

  localparam entry_t ENTRY_EMPTY = '1;

endpackage

// File: rtl/tournament_feed_slot.sv
// One request slot: holds its EMPTY/PENDING state and its arrival rank.
// The parent decides when to accept, clear or shift the rank down.
module tournament_feed_slot #(
  parameter int WIDTH_UNITS = pkg_bram_if::WIDTH_UNITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   accept,
  input  logic                   clear,
  input  logic                   dec,
  input  logic [WIDTH_UNITS-1:0] new_rank,
  output logic                   busy,
  output logic [WIDTH_UNITS-1:0] rank,
  output logic [WIDTH_UNITS:0]   entry
);
  import pkg_bram_if::*;

  slot_state_t state;

  // A cleared slot keeps its stale rank; it is masked by the EMPTY entry value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= SLOT_EMPTY;
      rank  <= '0;
    end else if (clear) begin
      state <= SLOT_EMPTY;
    end else if (accept) begin
      state <= SLOT_PENDING;
      rank  <= new_rank;
    end else if (dec) begin
      rank  <= rank - 1'b1;
    end
  end

  assign busy  = (state == SLOT_PENDING);
  assign entry = busy ? {1'b0, rank} : '1;

endmodule

// File: rtl/tournament_feed.sv
// Feeds request slots into an external tournament in arrival order and
// retires the granted winner, keeping pending ranks dense.
module tournament_feed #(
  parameter int NUM_UNITS   = pkg_bram_if::NUM_UNITS,
  parameter int WIDTH_UNITS = pkg_bram_if::WIDTH_UNITS
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_UNITS-1:0]                 I_Req,
  input  logic [NUM_UNITS-1:0]                 I_Win_Valid,
  input  logic                                 I_Grant,
  output logic [NUM_UNITS-1:0][WIDTH_UNITS:0]  O_Entry,
  output logic [NUM_UNITS-1:0]                 O_Busy,
  output logic                                 O_Req,
  output logic [WIDTH_UNITS:0]                 O_Count,
  output logic                                 O_Err
);
  import pkg_bram_if::*;

  logic [WIDTH_UNITS-1:0] rank     [NUM_UNITS];
  logic [WIDTH_UNITS-1:0] new_rank [NUM_UNITS];
  logic [NUM_UNITS-1:0]   accept;
  logic [NUM_UNITS-1:0]   clear;
  logic [NUM_UNITS-1:0]   dec;
  logic                   valid_grant;
  logic                   proto_err;
  logic [WIDTH_UNITS-1:0] win_rank;
  logic [WIDTH_UNITS:0]   base;
  logic [WIDTH_UNITS:0]   accepted;
  logic [WIDTH_UNITS:0]   count_next;

  // A bad grant freezes everything, including new requests, for that cycle.
  always_comb begin
    win_rank    = '0;
    accept      = '0;
    clear       = '0;
    dec         = '0;
    accepted    = '0;
    valid_grant = I_Grant && $onehot(I_Win_Valid) && ((I_Win_Valid & O_Busy) != '0);
    proto_err   = I_Grant && !valid_grant;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (I_Win_Valid[i] && O_Busy[i]) win_rank = win_rank | rank[i];
    end
    base = O_Count - {{WIDTH_UNITS{1'b0}}, valid_grant};
    for (int i = 0; i < NUM_UNITS; i++) begin
      accept[i]   = I_Req[i] && !O_Busy[i] && !proto_err;
      clear[i]    = valid_grant && I_Win_Valid[i];
      dec[i]      = valid_grant && O_Busy[i] && (rank[i] > win_rank);
      new_rank[i] = WIDTH_UNITS'(base + accepted);
      accepted    = accepted + {{WIDTH_UNITS{1'b0}}, accept[i]};
    end
    count_next = base + accepted;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      O_Count <= '0;
      O_Err   <= 1'b0;
    end else begin
      O_Count <= count_next;
      O_Err   <= proto_err;
    end
  end

  assign O_Req = (O_Count != '0);

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_slot
    tournament_feed_slot #(
      .WIDTH_UNITS(WIDTH_UNITS)
    ) u_slot (
      .clock    (clock),
      .reset    (reset),
      .accept   (accept[i]),
      .clear    (clear[i]),
      .dec      (dec[i]),
      .new_rank (new_rank[i]),
      .busy     (O_Busy[i]),
      .rank     (rank[i]),
      .entry    (O_Entry[i])
    );
  end

endmodule

// File: tb/tb_tournament_feed.sv
// Bench for tournament_feed: directed table, full-queue drain, then random
// traffic against an arrival-order queue model.
module tb_tournament_feed;
  import pkg_bram_if::*;

  logic                clock = 1'b0;
  logic                reset;
  logic [15:0]         I_Req;
  logic [15:0]         I_Win_Valid;
  logic                I_Grant;
  logic [15:0][4:0]    O_Entry;
  logic [15:0]         O_Busy;
  logic                O_Req;
  logic [4:0]          O_Count;
  logic                O_Err;

  int total = 0;
  int bad   = 0;

  int q[$];
  logic m_err;

  tournament_feed #(.NUM_UNITS(16), .WIDTH_UNITS(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .I_Req       (I_Req),
    .I_Win_Valid (I_Win_Valid),
    .I_Grant     (I_Grant),
    .O_Entry     (O_Entry),
    .O_Busy      (O_Busy),
    .O_Req       (O_Req),
    .O_Count     (O_Count),
    .O_Err       (O_Err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] wv;
    logic        grant;
    logic [63:0] exp_ord;
    int          exp_n;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  // Slot ids in arrival order, one nibble each, lowest nibble oldest.
  function automatic logic [79:0] entries_of(input logic [63:0] ord, input int n);
    logic [79:0] e;
    logic [3:0]  s;
    logic [3:0]  p;
    for (int i = 0; i < 16; i++) e[i*5 +: 5] = ENTRY_EMPTY;
    for (int k = 0; k < n; k++) begin
      s = ord[k*4 +: 4];
      p = 4'(k);
      e[s*5 +: 5] = {1'b0, p};
    end
    return e;
  endfunction

  function automatic logic [15:0] busy_of(input logic [63:0] ord, input int n);
    logic [15:0] b = '0;
    for (int k = 0; k < n; k++) b[ord[k*4 +: 4]] = 1'b1;
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] got, input logic [79:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic [15:0] req,
                               input logic [15:0] wv, input logic grant);
    @(negedge clock);
    reset       = rst_n;
    I_Req       = req;
    I_Win_Valid = wv;
    I_Grant     = grant;
    @(posedge clock);
    #1;
  endtask

  // Reference: pending slots are a queue in arrival order; rank = position.
  task automatic model_step(input logic rst_n, input logic [15:0] req,
                            input logic [15:0] wv, input logic grant);
    logic [15:0] pend;
    int          w;
    logic        valid;
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
      return;
    end
    pend = '0;
    foreach (q[k]) pend[q[k]] = 1'b1;
    w = -1;
    if ($onehot(wv)) for (int i = 0; i < 16; i++) if (wv[i]) w = i;
    valid = grant && (w >= 0) && pend[w];
    m_err = grant && !valid;
    if (!m_err) begin
      if (valid) begin
        for (int k = 0; k < q.size(); k++) if (q[k] == w) begin q.delete(k); break; end
      end
      for (int i = 0; i < 16; i++) if (req[i] && !pend[i]) q.push_back(i);
    end
  endtask

  task automatic check_model();
    logic [79:0] e;
    logic [15:0] b;
    e = '1;
    b = '0;
    foreach (q[k]) begin
      e[q[k]*5 +: 5] = {1'b0, 4'(k)};
      b[q[k]] = 1'b1;
    end
    checkOutput("rnd_entry", O_Entry, e);
    checkOutput("rnd_count_req_busy", {O_Count, O_Req, O_Busy}, {5'(q.size()), (q.size() != 0), b});
    checkOutput("rnd_err", O_Err, m_err);
  endtask

  initial begin
    int          win;
    logic [4:0]  best;
    logic [15:0] req, wv;
    logic        gr, rn;

    reset = 1'b0; I_Req = '0; I_Win_Valid = '0; I_Grant = 1'b0;

    vecs[0]  = '{1'b0, 16'hFFFF, 16'h0000, 1'b0, 64'h0,   0, 1'b0};
    vecs[1]  = '{1'b0, 16'hFFFF, 16'h0000, 1'b0, 64'h0,   0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0029, 16'h0000, 1'b0, 64'h530, 3, 1'b0};
    vecs[3]  = '{1'b1, 16'h0000, 16'h0008, 1'b1, 64'h50,  2, 1'b0};
    vecs[4]  = '{1'b1, 16'h0101, 16'h0001, 1'b1, 64'h85,  2, 1'b0};
    vecs[5]  = '{1'b1, 16'h0001, 16'h0000, 1'b0, 64'h085, 3, 1'b0};
    vecs[6]  = '{1'b1, 16'h0000, 16'h0003, 1'b1, 64'h085, 3, 1'b1};
    vecs[7]  = '{1'b1, 16'h0000, 16'h0002, 1'b1, 64'h085, 3, 1'b1};
    vecs[8]  = '{1'b1, 16'h0000, 16'h0000, 1'b0, 64'h085, 3, 1'b0};
    vecs[9]  = '{1'b1, 16'h0000, 16'h0003, 1'b0, 64'h085, 3, 1'b0};
    vecs[10] = '{1'b1, 16'h0020, 16'h0000, 1'b0, 64'h085, 3, 1'b0};
    vecs[11] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 64'h085, 3, 1'b1};
    vecs[12] = '{1'b0, 16'hFFFF, 16'h0020, 1'b1, 64'h0,   0, 1'b0};

    foreach (vecs[v]) begin
      applyStimulus(vecs[v].rst_n, vecs[v].req, vecs[v].wv, vecs[v].grant);
      checkOutput($sformatf("vec%0d_entry", v), O_Entry, entries_of(vecs[v].exp_ord, vecs[v].exp_n));
      checkOutput($sformatf("vec%0d_busy", v), O_Busy, busy_of(vecs[v].exp_ord, vecs[v].exp_n));
      checkOutput($sformatf("vec%0d_count", v), {O_Count, O_Req}, {5'(vecs[v].exp_n), (vecs[v].exp_n != 0)});
      checkOutput($sformatf("vec%0d_err", v), O_Err, vecs[v].exp_err);
    end

    // Fill every slot, then act as the tournament and drain by smallest entry.
    applyStimulus(1'b1, 16'hFFFF, 16'h0000, 1'b0);
    checkOutput("full_entry", O_Entry, entries_of(64'hFEDCBA9876543210, 16));
    checkOutput("full_count", O_Count, 5'd16);
    for (int g = 0; g < 16; g++) begin
      win  = 0;
      best = 5'h1F;
      for (int i = 0; i < 16; i++) if (O_Entry[i] < best) begin best = O_Entry[i]; win = i; end
      checkOutput($sformatf("drain%0d_winner", g), win, g);
      applyStimulus(1'b1, 16'h0000, 16'(1) << win, 1'b1);
      checkOutput($sformatf("drain%0d_count", g), O_Count, 5'(15 - g));
    end
    applyStimulus(1'b1, 16'h0000, 16'h0001, 1'b1);
    checkOutput("empty_grant_err", O_Err, 1'b1);
    checkOutput("empty_no_wrap", {O_Count, O_Busy}, 21'h0);

    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    model_step(1'b0, '0, '0, 1'b0);
    for (int c = 0; c < 2000; c++) begin
      rn  = ($urandom_range(99) != 0);
      req = 16'($urandom & $urandom & $urandom);
      gr  = ($urandom_range(2) != 0);
      if (q.size() != 0 && $urandom_range(9) < 8)
        wv = 16'(1) << q[$urandom_range(q.size() - 1)];
      else
        wv = 16'($urandom & $urandom);
      applyStimulus(rn, req, wv, gr);
      model_step(rn, req, wv, gr);
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
